// File: rtl/game_phase_sequencer_pkg.sv
// game_phase_sequencer_pkg: shared widths, state encoding, phase-length defaults and helpers
// Contents:
//   LEVEL_W, CNT_W           widths of the level and symbol counts
//   *_SECS_DEF               default phase lengths in 1 Hz ticks
//   S_*                      3-bit sequencer state encoding
//   flags_t / decode_flags   per-state period and result flags
//   abs_diff_sat             |a-b| computed one bit wider, saturated to CNT_W bits
package game_phase_sequencer_pkg;
  localparam int LEVEL_W = 5;
  localparam int CNT_W = 7;
  localparam int PRELIM_SECS_DEF = 3;
  localparam int GAME_SECS_DEF = 10;
  localparam int ANSWER_SECS_DEF = 5;
  localparam int POST_SECS_DEF = 3;
  localparam int MAX_LEVEL_DEF = 16;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRELIM = 3'd1;
  localparam logic [2:0] S_GAME = 3'd2;
  localparam logic [2:0] S_ANSWER = 3'd3;
  localparam logic [2:0] S_POST = 3'd4;
  localparam logic [2:0] S_LOST = 3'd5;
  localparam logic [2:0] S_WON = 3'd6;

  typedef struct packed {
    logic win;
    logic loss;
    logic post;
    logic answer;
    logic game;
    logic prelim;
  } flags_t;

  function automatic flags_t decode_flags(input logic [2:0] s);
    flags_t f;
    f.win = s == S_WON;
    f.loss = s == S_LOST;
    f.post = s == S_POST;
    f.answer = s == S_ANSWER;
    f.game = s == S_GAME;
    f.prelim = s == S_PRELIM;
    return f;
  endfunction

  function automatic logic [CNT_W-1:0] abs_diff_sat(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] d;
    d = (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, b} - {1'b0, a};
    return d[CNT_W] ? {CNT_W{1'b1}} : d[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/game_phase_sequencer_if.sv
// game_phase_sequencer_if: bundle between the phase sequencer and the game datapath
// Signals:
//   tick1Hz, start              1 Hz enable and debounced start pulse into the sequencer
//   userCount, gameCount        player count and generated special-symbol count
//   *Period / *PeriodB          phase flags and their one-cycle entry strobes
//   levelChng, level            level-advance strobe and current level
//   countDownTime               seconds left in the current phase
//   countDifference, loss, win  scoring result
// Modports: master = sequencer side, slave = consumers (generator, counter, display).
interface game_phase_sequencer_if;
  import game_phase_sequencer_pkg::*;
  logic tick1Hz;
  logic start;
  logic [CNT_W-1:0] userCount;
  logic [CNT_W-1:0] gameCount;
  logic prelimPeriod;
  logic gamePeriod;
  logic answerPeriod;
  logic postPeriod;
  logic prelimPeriodB;
  logic gamePeriodB;
  logic answerPeriodB;
  logic postPeriodB;
  logic levelChng;
  logic [3:0] countDownTime;
  logic [LEVEL_W-1:0] level;
  logic [CNT_W-1:0] countDifference;
  logic loss;
  logic win;

  modport master (
    input tick1Hz, start, userCount, gameCount,
    output prelimPeriod, gamePeriod, answerPeriod, postPeriod,
    output prelimPeriodB, gamePeriodB, answerPeriodB, postPeriodB,
    output levelChng, countDownTime, level, countDifference, loss, win
  );

  modport slave (
    output tick1Hz, start, userCount, gameCount,
    input prelimPeriod, gamePeriod, answerPeriod, postPeriod,
    input prelimPeriodB, gamePeriodB, answerPeriodB, postPeriodB,
    input levelChng, countDownTime, level, countDifference, loss, win
  );
endinterface

// File: rtl/game_phase_sequencer_phase_timer.sv
// phase_timer: 4-bit loadable down-counter that times one phase in 1 Hz ticks
// Ports:
//   Clk100M_i, resetN_i   clock and asynchronous active-low reset
//   load_i, load_val_i    load a new phase length (wins over tick)
//   tick_i                count enable
//   count_o               seconds left
//   expire_o              tick arriving on the last second (count==1)
module phase_timer (
  input  logic       Clk100M_i,
  input  logic       resetN_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       tick_i,
  output logic [3:0] count_o,
  output logic       expire_o
);
  logic [3:0] count_q, count_d;

  // The final tick does not decrement: the owner reloads on expire instead.
  assign count_d = load_i ? load_val_i : (tick_i && count_q > 4'd1) ? count_q - 4'd1 : count_q;
  assign expire_o = tick_i && count_q == 4'd1;
  assign count_o = count_q;

  always_ff @(posedge Clk100M_i or negedge resetN_i)
    if (!resetN_i) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/game_phase_sequencer.sv
// game_phase_sequencer: level/phase FSM of the symbol-counting game with scoring
// Ports:
//   Clk100M_i   100 MHz system clock
//   resetN_i    asynchronous active-low reset
//   bus         game_phase_sequencer_if.master (tick/start/counts in; flags, strobes,
//               countDownTime, level, countDifference, loss, win out; all registered)
module game_phase_sequencer
  import game_phase_sequencer_pkg::*;
#(
  parameter int PRELIM_SECS = PRELIM_SECS_DEF,
  parameter int GAME_SECS = GAME_SECS_DEF,
  parameter int ANSWER_SECS = ANSWER_SECS_DEF,
  parameter int POST_SECS = POST_SECS_DEF,
  parameter int MAX_LEVEL = MAX_LEVEL_DEF,
  parameter int TOLERANCE = 0
) (
  input logic Clk100M_i,
  input logic resetN_i,
  game_phase_sequencer_if.master bus
);
  logic [2:0] state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] diff_q, diff_d;
  logic [3:0] strobe_q, strobe_d;
  logic lvl_chng_q, lvl_chng_d;
  flags_t flags_q;
  logic load;
  logic [3:0] load_val;
  logic expire;
  logic idle_like;
  logic pass;
  logic [3:0] count;

  assign idle_like = state_q == S_IDLE || state_q == S_LOST || state_q == S_WON;
  assign pass = diff_q <= CNT_W'(TOLERANCE);

  // Ticks are masked outside the timed phases so a stray tick never reaches the timer.
  phase_timer u_timer (
    .Clk100M_i (Clk100M_i),
    .resetN_i  (resetN_i),
    .load_i    (load),
    .load_val_i(load_val),
    .tick_i    (bus.tick1Hz && !idle_like),
    .count_o   (count),
    .expire_o  (expire)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    diff_d = diff_q;
    lvl_chng_d = 1'b0;
    load = 1'b0;
    load_val = 4'd0;
    if (idle_like && bus.start) begin
      state_d = S_PRELIM;
      level_d = LEVEL_W'(1);
      load = 1'b1;
      load_val = 4'(PRELIM_SECS);
    end else if (!idle_like && expire) begin
      load = 1'b1;
      case (state_q)
        S_PRELIM: begin
          state_d = S_GAME;
          load_val = 4'(GAME_SECS);
        end
        S_GAME: begin
          state_d = S_ANSWER;
          load_val = 4'(ANSWER_SECS);
        end
        S_ANSWER: begin
          state_d = S_POST;
          load_val = 4'(POST_SECS);
          diff_d = abs_diff_sat(bus.userCount, bus.gameCount);
        end
        default: begin
          if (pass && level_q < LEVEL_W'(MAX_LEVEL)) begin
            state_d = S_PRELIM;
            level_d = level_q + LEVEL_W'(1);
            lvl_chng_d = 1'b1;
            load_val = 4'(PRELIM_SECS);
          end else begin
            state_d = pass ? S_WON : S_LOST;
          end
        end
      endcase
    end
  end

  // Entry strobes fire on any state change, including POST -> PRELIM on a level pass.
  assign strobe_d = (state_d != state_q) ?
    {state_d == S_POST, state_d == S_ANSWER, state_d == S_GAME, state_d == S_PRELIM} : 4'b0;

  always_ff @(posedge Clk100M_i or negedge resetN_i)
    if (!resetN_i) begin
      state_q <= S_IDLE;
      level_q <= LEVEL_W'(1);
      diff_q <= '0;
      strobe_q <= '0;
      lvl_chng_q <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      diff_q <= diff_d;
      strobe_q <= strobe_d;
      lvl_chng_q <= lvl_chng_d;
      flags_q <= decode_flags(state_d);
    end

  assign bus.prelimPeriod = flags_q.prelim;
  assign bus.gamePeriod = flags_q.game;
  assign bus.answerPeriod = flags_q.answer;
  assign bus.postPeriod = flags_q.post;
  assign bus.loss = flags_q.loss;
  assign bus.win = flags_q.win;
  assign bus.prelimPeriodB = strobe_q[0];
  assign bus.gamePeriodB = strobe_q[1];
  assign bus.answerPeriodB = strobe_q[2];
  assign bus.postPeriodB = strobe_q[3];
  assign bus.levelChng = lvl_chng_q;
  assign bus.countDownTime = count;
  assign bus.level = level_q;
  assign bus.countDifference = diff_q;
endmodule

// File: tb/tb_game_phase_sequencer.sv
// tb_game_phase_sequencer: directed scenarios plus random ticks/starts/counts against a phase-list model
module tb_game_phase_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_phase_sequencer_if ifa ();
  game_phase_sequencer_if ifb ();

  game_phase_sequencer #(.MAX_LEVEL(2)) dut_a (
    .Clk100M_i(clk), .resetN_i(rst_n), .bus(ifa)
  );
  game_phase_sequencer #(
    .PRELIM_SECS(2), .GAME_SECS(4), .ANSWER_SECS(3), .POST_SECS(1), .MAX_LEVEL(4), .TOLERANCE(2)
  ) dut_b (
    .Clk100M_i(clk), .resetN_i(rst_n), .bus(ifb)
  );

  // ph: 0 idle, 1 prelim, 2 game, 3 answer, 4 post, 5 lost, 6 won
  typedef struct {
    int ph;
    int cdt;
    int lvl;
    int diff;
    bit lc;
    bit [3:0] stb;
  } mdl_t;

  mdl_t m[2];
  int secs[2][5] = '{'{0, 3, 10, 5, 3}, '{0, 2, 4, 3, 1}};
  int maxl[2] = '{2, 4};
  int tol[2] = '{0, 2};
  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] fa, fb;

  assign fa = {ifa.win, ifa.loss, ifa.levelChng, ifa.postPeriodB, ifa.answerPeriodB, ifa.gamePeriodB,
               ifa.prelimPeriodB, ifa.postPeriod, ifa.answerPeriod, ifa.gamePeriod, ifa.prelimPeriod};
  assign fb = {ifb.win, ifb.loss, ifb.levelChng, ifb.postPeriodB, ifb.answerPeriodB, ifb.gamePeriodB,
               ifb.prelimPeriodB, ifb.postPeriod, ifb.answerPeriod, ifb.gamePeriod, ifb.prelimPeriod};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic mdl_t reset_m();
    mdl_t r;
    r.ph = 0;
    r.cdt = 0;
    r.lvl = 1;
    r.diff = 0;
    r.lc = 0;
    r.stb = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t cur, int k, bit tk, bit st, int u, int g);
    mdl_t r = cur;
    r.lc = 0;
    r.stb = 0;
    if (r.ph == 0 || r.ph >= 5) begin
      if (st) begin
        r.ph = 1;
        r.cdt = secs[k][1];
        r.lvl = 1;
        r.stb[0] = 1;
      end
    end else if (tk) begin
      if (r.cdt > 1) r.cdt--;
      else begin
        if (r.ph == 3) r.diff = (u > g) ? u - g : g - u;
        if (r.ph < 4) r.ph++;
        else if (r.diff <= tol[k] && r.lvl < maxl[k]) begin
          r.lvl++;
          r.lc = 1;
          r.ph = 1;
        end else r.ph = (r.diff <= tol[k]) ? 6 : 5;
        r.cdt = (r.ph <= 4) ? secs[k][r.ph] : 0;
        if (r.ph <= 4) r.stb[r.ph-1] = 1;
      end
    end
    return r;
  endfunction

  function automatic logic [10:0] exp_flags(mdl_t r);
    return {r.ph == 6, r.ph == 5, r.lc, r.stb, r.ph == 4, r.ph == 3, r.ph == 2, r.ph == 1};
  endfunction

  task automatic compare_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.%0d.flags", tag, k), k ? fb : fa, exp_flags(m[k]));
      chk($sformatf("%s.%0d.cdt", tag, k), k ? ifb.countDownTime : ifa.countDownTime, m[k].cdt);
      chk($sformatf("%s.%0d.level", tag, k), k ? ifb.level : ifa.level, m[k].lvl);
      chk($sformatf("%s.%0d.diff", tag, k), k ? ifb.countDifference : ifa.countDifference, m[k].diff);
    end
  endtask

  task automatic cyc(input bit tk, input bit st, input int u, input int g, input bit rn);
    rst_n = rn;
    ifa.tick1Hz = tk;
    ifb.tick1Hz = tk;
    ifa.start = st;
    ifb.start = st;
    ifa.userCount = 7'(u);
    ifb.userCount = 7'(u);
    ifa.gameCount = 7'(g);
    ifb.gameCount = 7'(g);
    for (int k = 0; k < 2; k++) m[k] = rn ? step(m[k], k, tk, st, u, g) : reset_m();
    @(negedge clk);
    compare_all("cyc");
  endtask

  task automatic tick_n(input int n, input int u, input int g);
    repeat (n) begin
      cyc(1, 0, u, g, 1);
      cyc(0, 0, u, g, 1);
    end
  endtask

  initial begin
    bit prev_tk;
    bit tk;
    bit st;
    bit rn;
    int u;
    int g;
    ifa.tick1Hz = 0; ifb.tick1Hz = 0;
    ifa.start = 0; ifb.start = 0;
    ifa.userCount = 0; ifb.userCount = 0;
    ifa.gameCount = 0; ifb.gameCount = 0;
    m[0] = reset_m();
    m[1] = reset_m();
    @(negedge clk);
    compare_all("reset");
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    // full level pass
    cyc(0, 1, 5, 5, 1);
    chk("t1_prelim_strobe", ifa.prelimPeriodB, 1);
    tick_n(21, 5, 5);
    chk("t1_level", ifa.level, 2);
    chk("t1_cdt", ifa.countDownTime, 3);
    chk("t1_prelim", ifa.prelimPeriod, 1);
    // failing level
    tick_n(21, 9, 5);
    chk("t2_diff", ifa.countDifference, 4);
    chk("t2_loss", ifa.loss, 1);
    chk("t2_level", ifa.level, 2);
    chk("t2_periods", {ifa.prelimPeriod, ifa.gamePeriod, ifa.answerPeriod, ifa.postPeriod}, 0);
    // win at MAX_LEVEL, then restart
    cyc(0, 1, 5, 5, 1);
    chk("t3_loss_clr", ifa.loss, 0);
    tick_n(42, 5, 5);
    chk("t3_win", ifa.win, 1);
    chk("t3_level", ifa.level, 2);
    cyc(0, 1, 5, 5, 1);
    chk("t3_restart_level", ifa.level, 1);
    chk("t3_restart_win", ifa.win, 0);
    chk("t3_restart_prelim", ifa.prelimPeriod, 1);
    // start and tick together in IDLE
    cyc(0, 0, 5, 5, 0);
    cyc(0, 0, 5, 5, 1);
    cyc(1, 1, 5, 5, 1);
    chk("t4_cdt", ifa.countDownTime, 3);
    // start ignored in GAME
    tick_n(3, 5, 5);
    cyc(0, 1, 5, 5, 1);
    cyc(1, 1, 5, 5, 1);
    cyc(0, 1, 5, 5, 1);
    chk("t5_game", ifa.gamePeriod, 1);
    chk("t5_cdt", ifa.countDownTime, 9);
    chk("t5_level", ifa.level, 1);
    // asynchronous reset mid-GAME
    tick_n(5, 5, 5);
    chk("t6_cdt_before", ifa.countDownTime, 4);
    rst_n = 0;
    #1;
    chk("t6_async_flags", fa, 0);
    chk("t6_async_cdt", ifa.countDownTime, 0);
    chk("t6_async_level", ifa.level, 1);
    m[0] = reset_m();
    m[1] = reset_m();
    @(negedge clk);
    compare_all("t6_hold");
    cyc(0, 0, 5, 5, 1);
    // random
    prev_tk = 0;
    repeat (4000) begin
      tk = !prev_tk && $urandom_range(2) == 0;
      st = $urandom_range(29) == 0;
      rn = $urandom_range(999) != 0;
      g = $urandom_range(127);
      if ($urandom_range(3) == 0) u = $urandom_range(127);
      else if ($urandom_range(1) == 0) u = g;
      else begin
        u = g + int'($urandom_range(6)) - 3;
        u = u < 0 ? 0 : (u > 127 ? 127 : u);
      end
      cyc(tk, st, u, g, rn);
      prev_tk = tk;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
